// File: rtl/led_seg_pkg.sv
// ---------------------------------------------------------------------------
// led_seg_pkg
//   Shared definitions for the multiplexed 7-segment display path.
//   Segment patterns are active-low and packed as {g,f,e,d,c,b,a}.
//   Holds the pattern constants, the digit code constants and the scan
//   decoder FSM state encoding. Also used by the display driver side.
// ---------------------------------------------------------------------------
package led_seg_pkg;

   localparam logic [6:0] SEG_ZERO  = 7'h40;
   localparam logic [6:0] SEG_ONE   = 7'h79;
   localparam logic [6:0] SEG_TWO   = 7'h24;
   localparam logic [6:0] SEG_THREE = 7'h30;
   localparam logic [6:0] SEG_FOUR  = 7'h19;
   localparam logic [6:0] SEG_FIVE  = 7'h12;
   localparam logic [6:0] SEG_SIX   = 7'h02;
   localparam logic [6:0] SEG_SEVEN = 7'h78;
   localparam logic [6:0] SEG_EIGHT = 7'h00;
   localparam logic [6:0] SEG_NINE  = 7'h18;
   localparam logic [6:0] SEG_NONE  = 7'h7F;

   localparam logic [3:0] CODE_BLANK   = 4'hA;
   localparam logic [3:0] CODE_INVALID = 4'hE;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } scan_state_t;

endpackage

// File: rtl/seg7_to_code.sv
// ---------------------------------------------------------------------------
// seg7_to_code
//   Combinational decode of an active-low segment pattern into a digit code.
//   Ports:
//     seg     in  7  segment pattern {g,f,e,d,c,b,a}, active-low
//     code    out 4  0-9, CODE_BLANK for all-dark, CODE_INVALID otherwise
//     invalid out 1  pattern is not one of the eleven known shapes
// ---------------------------------------------------------------------------
module seg7_to_code
   import led_seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] code,
   output logic       invalid
);

   // Table lookup; anything that is not a recognised glyph or a dark digit
   // is flagged so the caller can record it against the digit position.
   always_comb begin
      code    = CODE_INVALID;
      invalid = 1'b0;
      case (seg)
         SEG_ZERO:  code = 4'd0;
         SEG_ONE:   code = 4'd1;
         SEG_TWO:   code = 4'd2;
         SEG_THREE: code = 4'd3;
         SEG_FOUR:  code = 4'd4;
         SEG_FIVE:  code = 4'd5;
         SEG_SIX:   code = 4'd6;
         SEG_SEVEN: code = 4'd7;
         SEG_EIGHT: code = 4'd8;
         SEG_NINE:  code = 4'd9;
         SEG_NONE:  code = CODE_BLANK;
         default: begin
            code    = CODE_INVALID;
            invalid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/led_scan_decoder.sv
// ---------------------------------------------------------------------------
// led_scan_decoder
//   Snoops the scanned 8-digit 7-segment bus and rebuilds the displayed
//   digits as codes, publishing a full frame once every position is seen.
//   Parameters: SETTLE (stable cycles before capture, >=1),
//               TIMEOUT (cycles without capture before locked drops, >=2).
//   Optional feature macro: LED_SCAN_DP_CAPTURE_EN (decimal point capture).
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     led_en[7:0]        digit enables, active-low, bit7 = leftmost digit
//     led_ca..led_cg     segment lines, active-low
//     led_dp             decimal point, active-low
//     digits[31:0]       digit i in digits[4i+3:4i]
//     dp_out[7:0]        captured decimal points, active-high
//     frame_valid        one-cycle pulse when digits/dp_out update
//     seg_err[7:0]       sticky, undecodable pattern captured per digit
//     en_err             sticky, more than one enable was low
//     locked             high from first frame until capture timeout
// ---------------------------------------------------------------------------
module led_scan_decoder
   import led_seg_pkg::*;
#(
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 1024
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  led_en,
   input  logic        led_ca,
   input  logic        led_cb,
   input  logic        led_cc,
   input  logic        led_cd,
   input  logic        led_ce,
   input  logic        led_cf,
   input  logic        led_cg,
   input  logic        led_dp,
   output logic [31:0] digits,
   output logic [7:0]  dp_out,
   output logic        frame_valid,
   output logic [7:0]  seg_err,
   output logic        en_err,
   output logic        locked
);

   localparam int SW = $clog2(SETTLE + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam scan_state_t FIRST_ST = (SETTLE == 1) ? ST_CAPTURE : ST_SETTLE;

   logic [7:0]    s_en, p_en, hold_en, en_low;
   logic [6:0]    s_seg, p_seg, cap_seg;
   logic [2:0]    en_idx, cap_idx;
   logic [3:0]    cap_code;
   logic          cap_invalid;
   logic          one_cold, multi_cold, stable, to_hit, publish, cap_load;
   scan_state_t   state;
   logic [SW-1:0] stab_cnt;
   logic [TW-1:0] to_cnt;
   logic [31:0]   shadow;
   logic [7:0]    seen;

   // Classify the registered enables. A one-cold word selects a digit; more
   // than one low bit is a bus fault. Capture values are refreshed on every
   // cycle where the FSM is still deciding, so on entry to CAPTURE they hold
   // exactly the sample that passed the stability check. In HOLD they stay
   // frozen so a bus change during CAPTURE is still seen afterwards.
   always_comb begin
      en_low     = ~s_en;
      multi_cold = |(en_low & (en_low - 8'd1));
      one_cold   = (en_low != 8'd0) && !multi_cold;
      en_idx     = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (!s_en[i]) en_idx = 3'(i);
      end
      stable   = (s_en == p_en) && (s_seg == p_seg);
      to_hit   = (to_cnt == TW'(TIMEOUT - 1));
      publish  = (seen == 8'hFF);
      cap_load = (state == ST_IDLE) || (state == ST_SETTLE) ||
                 ((state == ST_HOLD) && (s_en != hold_en));
   end

   // Input synchroniser plus a one-cycle history used to judge stability.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_en  <= 8'hFF;
         p_en  <= 8'hFF;
         s_seg <= SEG_NONE;
         p_seg <= SEG_NONE;
      end else begin
         s_en  <= led_en;
         s_seg <= {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};
         p_en  <= s_en;
         p_seg <= s_seg;
      end
   end

   // Scan tracking FSM. A digit must stay unchanged for SETTLE cycles before
   // it is captured; any change restarts the count. After a capture we park
   // in HOLD until the bus moves on, so one slot yields one capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         stab_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (one_cold) begin
                  state    <= FIRST_ST;
                  stab_cnt <= SW'(1);
               end
            end
            ST_SETTLE: begin
               if (stable) begin
                  if ((stab_cnt + SW'(1)) >= SW'(SETTLE)) state <= ST_CAPTURE;
                  else stab_cnt <= stab_cnt + SW'(1);
               end else if (one_cold) begin
                  stab_cnt <= SW'(1);
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_CAPTURE: begin
               state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (s_en != hold_en) begin
                  if (one_cold) begin
                     state    <= FIRST_ST;
                     stab_cnt <= SW'(1);
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Snapshot of the digit being qualified; written into the shadow during
   // the CAPTURE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_idx <= 3'd0;
         cap_seg <= SEG_NONE;
         hold_en <= 8'hFF;
      end else if (cap_load) begin
         cap_idx <= en_idx;
         cap_seg <= s_seg;
         hold_en <= s_en;
      end
   end

   seg7_to_code u_dec (
      .seg     (cap_seg),
      .code    (cap_code),
      .invalid (cap_invalid)
   );

   // Watchdog on captures: counts idle cycles and saturates, so a stopped
   // scan eventually drops lock and discards any partial frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (state == ST_CAPTURE) begin
         to_cnt <= '0;
      end else if (!to_hit) begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   // Frame assembly. Captures land in the shadow and mark the position as
   // seen; once all eight are present the shadow is published the next
   // cycle. Clearing of seen is ordered before the capture bit set, so a
   // capture coinciding with a timeout is not dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow      <= 32'hAAAA_AAAA;
         seen        <= 8'h00;
         digits      <= 32'hAAAA_AAAA;
         frame_valid <= 1'b0;
         seg_err     <= 8'h00;
         en_err      <= 1'b0;
         locked      <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         if (multi_cold) en_err <= 1'b1;
         if (publish) begin
            digits      <= shadow;
            frame_valid <= 1'b1;
            locked      <= 1'b1;
         end else if (to_hit) begin
            locked <= 1'b0;
         end
         if (publish || to_hit) seen <= 8'h00;
         if (state == ST_CAPTURE) begin
            shadow[{cap_idx, 2'b00} +: 4] <= cap_code;
            seen[cap_idx]                 <= 1'b1;
            if (cap_invalid) seg_err[cap_idx] <= 1'b1;
         end
      end
   end

`ifdef LED_SCAN_DP_CAPTURE_EN
   logic       s_dp, cap_dp;
   logic [7:0] dp_shadow;

   // Decimal point path follows the same sample/capture/publish timing as
   // the segments, stored active-high.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_dp      <= 1'b1;
         cap_dp    <= 1'b0;
         dp_shadow <= 8'h00;
         dp_out    <= 8'h00;
      end else begin
         s_dp <= led_dp;
         if (cap_load) cap_dp <= ~s_dp;
         if (state == ST_CAPTURE) dp_shadow[cap_idx] <= cap_dp;
         if (publish) dp_out <= dp_shadow;
      end
   end
`else
   logic unused_dp;

   assign dp_out    = 8'h00;
   assign unused_dp = led_dp;
`endif

endmodule
